// File: rtl/formation_move_if.sv
// Control/status bundle between game logic and the invader formation mover.
interface formation_move_if #(
  parameter int POS_W = 10,
  parameter int CNT_W = 6
);
  logic             enable;
  logic             restart;
  logic [CNT_W-1:0] alive_count;
  logic [POS_W-1:0] xpos;
  logic [POS_W-1:0] ypos;
  logic             dir;
  logic             step_pulse;
  logic             reached_bottom;

  modport master (
    output enable, restart, alive_count,
    input  xpos, ypos, dir, step_pulse, reached_bottom
  );

  modport slave (
    input  enable, restart, alive_count,
    output xpos, ypos, dir, step_pulse, reached_bottom
  );
endinterface

// File: rtl/formation_move.sv
// Invader formation anchor: sweeps between X bounds, steps down at each edge,
// and speeds up as fewer invaders remain alive.
module formation_move #(
  parameter int POS_W           = 10,
  parameter int CNT_W           = 6,
  parameter int DIV_W           = 32,
  parameter int DIV_MIN         = 1_083_333,
  parameter int DIV_PER_INVADER = 65_000,
  parameter int X_START         = 0,
  parameter int Y_START         = 0,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 200,
  parameter int X_STEP          = 2,
  parameter int Y_STEP          = 16,
  parameter int Y_LIMIT         = 400
) (
  input logic             clk65MHz,
  input logic             rst_n,
  formation_move_if.slave bus
);

  localparam int PW = POS_W + 1;

  localparam logic [PW-1:0]    XMIN_W    = PW'(X_MIN);
  localparam logic [PW-1:0]    XMAX_W    = PW'(X_MAX);
  localparam logic [PW-1:0]    XSTEP_W   = PW'(X_STEP);
  localparam logic [PW-1:0]    YSTEP_W   = PW'(Y_STEP);
  localparam logic [PW-1:0]    YLIM_W    = PW'(Y_LIMIT);
  localparam logic [POS_W-1:0] X_START_P = POS_W'(X_START);
  localparam logic [POS_W-1:0] Y_START_P = POS_W'(Y_START);
  localparam logic [POS_W-1:0] X_MIN_P   = POS_W'(X_MIN);
  localparam logic [POS_W-1:0] X_MAX_P   = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] X_STEP_P  = POS_W'(X_STEP);
  localparam logic [POS_W-1:0] Y_LIMIT_P = POS_W'(Y_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    RIGHT,
    DOWN_RIGHT,
    LEFT,
    DOWN_LEFT,
    LANDED
  } state_t;

  state_t           state, state_nxt;
  logic [POS_W-1:0] x_reg, x_nxt;
  logic [POS_W-1:0] y_reg, y_nxt;
  logic             dir_reg, dir_nxt;
  logic             step_reg, step_nxt;
  logic             bottom_reg, bottom_nxt;
  logic [DIV_W-1:0] divider, div_nxt;
  logic             tick, tick_nxt;

  logic [CNT_W-1:0] alive;
  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] period_last;
  logic [PW-1:0]    x_wide;
  logic [PW-1:0]    x_ahead;
  logic [PW-1:0]    y_ahead;

  assign alive       = bus.alive_count;
  assign period      = DIV_W'(DIV_MIN) + DIV_W'(alive) * DIV_W'(DIV_PER_INVADER);
  assign period_last = period - DIV_W'(1);

  // Bound checks are done one bit wider so a step past the edge cannot wrap.
  assign x_wide  = {1'b0, x_reg};
  assign x_ahead = x_wide + XSTEP_W;
  assign y_ahead = {1'b0, y_reg} + YSTEP_W;

  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_reg      <= X_START_P;
      y_reg      <= Y_START_P;
      dir_reg    <= 1'b0;
      step_reg   <= 1'b0;
      bottom_reg <= 1'b0;
      divider    <= '0;
      tick       <= 1'b0;
    end else begin
      state      <= state_nxt;
      x_reg      <= x_nxt;
      y_reg      <= y_nxt;
      dir_reg    <= dir_nxt;
      step_reg   <= step_nxt;
      bottom_reg <= bottom_nxt;
      divider    <= div_nxt;
      tick       <= tick_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    x_nxt      = x_reg;
    y_nxt      = y_reg;
    dir_nxt    = dir_reg;
    step_nxt   = 1'b0;
    bottom_nxt = bottom_reg;
    div_nxt    = divider;
    tick_nxt   = 1'b0;

    if (bus.enable && (state != LANDED)) begin
      if (divider >= period_last) begin
        div_nxt  = '0;
        tick_nxt = 1'b1;
      end else begin
        div_nxt = divider + DIV_W'(1);
      end
    end

    if (tick && bus.enable) begin
      case (state)
        IDLE: state_nxt = RIGHT;
        RIGHT: begin
          step_nxt = 1'b1;
          if (x_ahead >= XMAX_W) begin
            x_nxt     = X_MAX_P;
            state_nxt = DOWN_RIGHT;
          end else begin
            x_nxt = x_ahead[POS_W-1:0];
          end
        end
        DOWN_RIGHT, DOWN_LEFT: begin
          step_nxt = 1'b1;
          if (y_ahead >= YLIM_W) begin
            y_nxt      = Y_LIMIT_P;
            bottom_nxt = 1'b1;
            state_nxt  = LANDED;
          end else begin
            y_nxt     = y_ahead[POS_W-1:0];
            dir_nxt   = (state == DOWN_RIGHT);
            state_nxt = (state == DOWN_RIGHT) ? LEFT : RIGHT;
          end
        end
        LEFT: begin
          step_nxt = 1'b1;
          if (x_wide <= (XMIN_W + XSTEP_W)) begin
            x_nxt     = X_MIN_P;
            state_nxt = DOWN_LEFT;
          end else begin
            x_nxt = x_reg - X_STEP_P;
          end
        end
        LANDED:  state_nxt = LANDED;
        default: state_nxt = IDLE;
      endcase
    end

    // Restart overrides the divider and any move decided above.
    if (bus.restart) begin
      state_nxt  = IDLE;
      x_nxt      = X_START_P;
      y_nxt      = Y_START_P;
      dir_nxt    = 1'b0;
      step_nxt   = 1'b0;
      bottom_nxt = 1'b0;
      div_nxt    = '0;
      tick_nxt   = 1'b0;
    end
  end

  assign bus.xpos           = x_reg;
  assign bus.ypos           = y_reg;
  assign bus.dir            = dir_reg;
  assign bus.step_pulse     = step_reg;
  assign bus.reached_bottom = bottom_reg;

endmodule

// File: tb/tb_formation_move.sv
// Directed bench for formation_move: sweep, landing, speed-up, pause, tick
// masking, restart and asynchronous reset, all with hand-computed values.
module tb_formation_move;

  logic clk65MHz;
  logic rst_n;
  int   checks;
  int   passes;
  int   pulses;
  int   bad;

  int exp_x [1:13] = '{0, 4, 8, 10, 10, 6, 2, 0, 0, 4, 8, 10, 10};
  int exp_y [1:13] = '{0, 0, 0, 0, 16, 16, 16, 16, 32, 32, 32, 32, 40};
  int exp_d [1:13] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};

  formation_move_if #(.POS_W(10), .CNT_W(6)) fm_bus ();

  formation_move #(
    .POS_W(10), .CNT_W(6), .DIV_W(32),
    .DIV_MIN(4), .DIV_PER_INVADER(2),
    .X_START(0), .Y_START(0), .X_MIN(0), .X_MAX(10), .X_STEP(4),
    .Y_STEP(16), .Y_LIMIT(40)
  ) dut (
    .clk65MHz (clk65MHz),
    .rst_n    (rst_n),
    .bus      (fm_bus)
  );

  initial clk65MHz = 1'b0;
  always #5 clk65MHz = ~clk65MHz;

  task automatic tick_clock(input int n);
    repeat (n) @(posedge clk65MHz);
    @(negedge clk65MHz);
  endtask

  task automatic applyStimulus(input logic en, input logic rs, input logic [5:0] alive);
    fm_bus.enable      = en;
    fm_bus.restart     = rs;
    fm_bus.alive_count = alive;
  endtask

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic checkOutput(input string tag, input int x, input int y, input int d,
                             input int sp, input int rb);
    check_value({tag, ".xpos"}, 32'(fm_bus.xpos), 32'(x));
    check_value({tag, ".ypos"}, 32'(fm_bus.ypos), 32'(y));
    check_value({tag, ".dir"}, 32'(fm_bus.dir), 32'(d));
    check_value({tag, ".step_pulse"}, 32'(fm_bus.step_pulse), 32'(sp));
    check_value({tag, ".reached_bottom"}, 32'(fm_bus.reached_bottom), 32'(rb));
  endtask

  initial begin
    checks = 0;
    passes = 0;
    pulses = 0;
    bad    = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b1, 1'b0, 6'd0);
    @(negedge clk65MHz);
    checkOutput("reset", 0, 0, 0, 0, 0);
    @(negedge clk65MHz);
    rst_n = 1'b1;
    $display("[TB] sweep and landing, alive_count=0");

    // Tick n is applied on edge 4n+1 after reset release.
    for (int e = 1; e <= 53; e++) begin
      tick_clock(1);
      if (e >= 6 && e <= 37 && fm_bus.step_pulse === 1'b1) pulses++;
      if (e >= 5 && ((e - 1) % 4) == 0)
        checkOutput($sformatf("sweep_t%0d", (e - 1) / 4), exp_x[(e - 1) / 4],
                    exp_y[(e - 1) / 4], exp_d[(e - 1) / 4],
                    ((e - 1) / 4 >= 2) ? 1 : 0, ((e - 1) / 4 == 13) ? 1 : 0);
    end
    check_value("pulse_count", 32'(pulses), 32'd8);

    for (int i = 0; i < 100; i++) begin
      tick_clock(1);
      if (fm_bus.xpos !== 10'd10 || fm_bus.ypos !== 10'd40 || fm_bus.dir !== 1'b0 ||
          fm_bus.step_pulse !== 1'b0 || fm_bus.reached_bottom !== 1'b1) bad++;
    end
    check_value("landed_hold", 32'(bad), 32'd0);

    $display("[TB] restart from landed, speed-up");
    applyStimulus(1'b1, 1'b1, 6'd3);
    tick_clock(1);
    applyStimulus(1'b1, 1'b0, 6'd3);
    checkOutput("restart_landed", 0, 0, 0, 0, 0);
    tick_clock(20);
    checkOutput("p10_pre1", 0, 0, 0, 0, 0);
    tick_clock(1);
    checkOutput("p10_move1", 4, 0, 0, 1, 0);
    tick_clock(9);
    checkOutput("p10_pre2", 4, 0, 0, 0, 0);
    tick_clock(1);
    checkOutput("p10_move2", 8, 0, 0, 1, 0);
    tick_clock(6);
    applyStimulus(1'b1, 1'b0, 6'd1);
    tick_clock(1);
    checkOutput("drop_tick", 8, 0, 0, 0, 0);
    tick_clock(1);
    checkOutput("drop_move", 10, 0, 0, 1, 0);
    tick_clock(5);
    checkOutput("p6_pre", 10, 0, 0, 0, 0);
    tick_clock(1);
    checkOutput("p6_move", 10, 16, 1, 1, 0);

    $display("[TB] pause mid-period");
    tick_clock(2);
    applyStimulus(1'b0, 1'b0, 6'd1);
    tick_clock(20);
    checkOutput("paused", 10, 16, 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 6'd1);
    tick_clock(3);
    checkOutput("resume_pre", 10, 16, 1, 0, 0);
    tick_clock(1);
    checkOutput("resume_move", 6, 16, 1, 1, 0);

    $display("[TB] restart while moving left");
    applyStimulus(1'b1, 1'b1, 6'd1);
    tick_clock(1);
    applyStimulus(1'b1, 1'b0, 6'd1);
    checkOutput("restart_left", 0, 0, 0, 0, 0);
    tick_clock(12);
    checkOutput("idle_exit", 0, 0, 0, 0, 0);
    tick_clock(1);
    checkOutput("first_move", 4, 0, 0, 1, 0);

    $display("[TB] tick masked by enable drop");
    tick_clock(5);
    applyStimulus(1'b0, 1'b0, 6'd1);
    tick_clock(1);
    checkOutput("masked", 4, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 6'd1);
    tick_clock(6);
    checkOutput("after_mask_pre", 4, 0, 0, 0, 0);
    tick_clock(1);
    checkOutput("after_mask_move", 8, 0, 0, 1, 0);

    $display("[TB] asynchronous reset");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 0, 0, 0, 0, 0);
    tick_clock(2);
    checkOutput("reset_held", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
